// File: rtl/spi_slave_stream.sv
// -----------------------------------------------------------------------------
// spi_slave_stream
//
// SPI slave front-end clocked entirely by the system clock. While SS_n is low,
// MOSI is sampled on every rising edge of clk and assembled MSB first into
// frames of FRAME_W = DATA_W+2 bits. Each complete frame is presented on
// rx_data with a one-cycle rx_valid pulse. The top two frame bits are the
// command:
//   00 write-address, 01 write-data, 10 read-address, 11 read-data.
// After a read-data command, the block waits for tx_valid. It then accepts
// tx_data with a one-cycle tx_ack pulse and shifts the word out on MISO,
// MSB first.
//
// Raising SS_n on any edge aborts whatever is in progress. A partial frame is
// dropped without an rx_valid pulse, and rx_data keeps the last complete
// frame.
//
// Compile-time option:
//   SPI_SLAVE_STREAM_BURST_EN
//     defined   : frames stream back-to-back under one SS_n assertion. After a
//                 read word, the block re-arms for the next tx_valid.
//     undefined : at most one frame plus one read word per SS_n assertion.
//                 Anything after that is ignored (HOLD) until SS_n rises.
//
// Parameters:
//   DATA_W     payload width (>= 2)
//   MISO_IDLE  MISO level whenever no read word is being shifted out
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   SS_n       in   slave select, active-low
//   MOSI       in   serial data in, MSB first
//   tx_valid   in   tx_data holds a read word ready to send
//   tx_data    in   read word (DATA_W)
//   tx_ack     out  one-cycle pulse: tx_data accepted on this edge
//   MISO       out  serial data out, MSB first, registered
//   rx_valid   out  one-cycle pulse: rx_data holds a complete frame
//   rx_data    out  last complete frame (FRAME_W), command in top two bits
//   busy       out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module spi_slave_stream #(
    parameter int   DATA_W    = 8,
    parameter logic MISO_IDLE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ack,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              busy
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_TX_WAIT,
        S_TX,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    state_t              state_q;
    logic [CNT_W-1:0]    bit_cnt_q;   // frame bits captured so far
    logic [CNT_W-1:0]    tx_cnt_q;    // read-word bits already driven onto MISO
    // Holds only the bits still needed: the frame's oldest bit leaves the
    // register on the same edge that the newest one arrives.
    logic [FRAME_W-2:0]  frame_q;
    logic [DATA_W-1:0]   tx_shift_q;
    logic [FRAME_W-1:0]  rx_data_q;
    logic                rx_valid_q;
    logic                tx_ack_q;
    logic                miso_q;
    logic                busy_q;

    // Frame as it would look after shifting in the current MOSI bit. On the
    // last bit of a frame, this is exactly the completed frame.
    logic [FRAME_W-1:0]  frame_d;
    logic [1:0]          cmd_d;
    logic                frame_done;
    logic                tx_last;

    assign frame_d    = {frame_q, MOSI};
    assign cmd_d      = frame_d[FRAME_W-1 -: 2];
    assign frame_done = (bit_cnt_q == CNT_W'(FRAME_W - 1));
    // The LSB has been on MISO for one full cycle once all DATA_W bits are out.
    assign tx_last    = (tx_cnt_q == CNT_W'(DATA_W));

    // NOTE: every register below is written with non-blocking assignments, so
    // all branches see the pre-edge values and no ordering hazards arise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            tx_cnt_q   <= '0;
            frame_q    <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ack_q   <= 1'b0;
            miso_q     <= MISO_IDLE;
            busy_q     <= 1'b0;
        end else begin
            // Strobes default low and are raised only on their event edge.
            rx_valid_q <= 1'b0;
            tx_ack_q   <= 1'b0;

            if (SS_n) begin
                // Deselect aborts from any state. rx_data is deliberately kept.
                state_q    <= S_IDLE;
                bit_cnt_q  <= '0;
                tx_cnt_q   <= '0;
                frame_q    <= '0;
                tx_shift_q <= '0;
                miso_q     <= MISO_IDLE;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // The first sampled bit is the frame MSB.
                        frame_q   <= {{(FRAME_W-2){1'b0}}, MOSI};
                        bit_cnt_q <= CNT_W'(1);
                        state_q   <= S_RX;
                        busy_q    <= 1'b1;
                    end

                    S_RX: begin
                        frame_q <= frame_d[FRAME_W-2:0];
                        if (frame_done) begin
                            rx_data_q  <= frame_d;
                            rx_valid_q <= 1'b1;
                            bit_cnt_q  <= '0;
                            if (cmd_d == CMD_RD_DATA) begin
                                state_q <= S_TX_WAIT;
                            end else begin
`ifdef SPI_SLAVE_STREAM_BURST_EN
                                // Count 0 here means the next edge carries the
                                // next frame's MSB, so there are no gap cycles.
                                state_q <= S_RX;
`else
                                state_q <= S_HOLD;
`endif
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end

                    S_TX_WAIT: begin
                        // MOSI is ignored here; the block is only waiting for a
                        // read word.
                        if (tx_valid) begin
                            tx_ack_q   <= 1'b1;
                            miso_q     <= tx_data[DATA_W-1];
                            tx_shift_q <= {tx_data[DATA_W-2:0], 1'b0};
                            tx_cnt_q   <= CNT_W'(1);
                            state_q    <= S_TX;
                        end
                    end

                    S_TX: begin
                        if (tx_last) begin
                            miso_q     <= MISO_IDLE;
                            tx_cnt_q   <= '0;
                            tx_shift_q <= '0;
`ifdef SPI_SLAVE_STREAM_BURST_EN
                            state_q    <= S_TX_WAIT;
`else
                            state_q    <= S_HOLD;
`endif
                        end else begin
                            miso_q     <= tx_shift_q[DATA_W-1];
                            tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                            tx_cnt_q   <= tx_cnt_q + CNT_W'(1);
                        end
                    end

                    S_HOLD: begin
                        // Everything is ignored until SS_n rises.
                        state_q <= S_HOLD;
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ack   = tx_ack_q;
    assign MISO     = miso_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_slave_stream.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_stream
//
// Directed bench for spi_slave_stream with DATA_W=8 and MISO_IDLE=0. Inputs
// are driven 1 time unit after each rising edge. Outputs are sampled at the
// same point, so every step observes the result of exactly one clock edge.
// The burst-dependent expectations follow SPI_SLAVE_STREAM_BURST_EN.
// -----------------------------------------------------------------------------
module tb_spi_slave_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       MISO;
    logic       rx_valid;
    logic [9:0] rx_data;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;

    spi_slave_stream #(
        .DATA_W   (8),
        .MISO_IDLE(1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ack  (tx_ack),
        .MISO    (MISO),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Shifts a frame in MSB first, one bit per edge. Between bits, no frame
    // may complete, no read word may be accepted, and the block must be busy.
    task automatic send_frame(input logic [9:0] f);
        for (int i = 9; i >= 0; i--) begin
            SS_n = 1'b0;
            MOSI = f[i];
            step();
            check("rx busy", busy, 1);
            check("rx tx_ack", tx_ack, 0);
            if (i != 0) check("rx mid rx_valid", rx_valid, 0);
        end
    endtask

    initial begin
        logic [7:0] word;

        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        step();
        step();
        check("reset MISO", MISO, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset tx_ack", tx_ack, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        step();
        check("idle busy", busy, 0);

        // Write frame 00_1010_0101.
        send_frame(10'h0A5);
        check("wr rx_valid", rx_valid, 1);
        check("wr rx_data", rx_data, 10'h0A5);
        check("wr tx_ack", tx_ack, 0);
        MOSI = 1'b0;
        step();
        check("wr rx_valid pulse end", rx_valid, 0);
        check("wr tx_ack after", tx_ack, 0);
        SS_n = 1'b1;
        step();
        check("wr deselect busy", busy, 0);

        // Read-data frame; tx_valid arrives 3 cycles after the frame completes.
        send_frame(10'h300);
        check("rd rx_valid", rx_valid, 1);
        check("rd rx_data", rx_data, 10'h300);
        MOSI = 1'b1;  // MOSI is ignored while waiting for a read word.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rd wait tx_ack", tx_ack, 0);
            check("rd wait MISO", MISO, 0);
            check("rd wait rx_valid", rx_valid, 0);
        end
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        step();
        check("rd accept tx_ack", tx_ack, 1);
        check("rd MISO bit7", MISO, 1);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        word     = 8'hC3;
        for (int i = 6; i >= 0; i--) begin
            step();
            check("rd tx_ack single", tx_ack, 0);
            check("rd MISO bit", MISO, word[i]);
        end
        step();
        check("rd MISO back idle", MISO, 0);
        check("rd busy after word", busy, 1);
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        step();
`ifdef SPI_SLAVE_STREAM_BURST_EN
        check("rd rearm tx_ack", tx_ack, 1);
`else
        check("rd hold tx_ack", tx_ack, 0);
`endif
        check("rd second MISO", MISO, 0);
        tx_valid = 1'b0;
        SS_n     = 1'b1;
        step();
        check("rd deselect MISO", MISO, 0);
        check("rd deselect busy", busy, 0);
        check("rd deselect tx_ack", tx_ack, 0);

        // Abort after 6 bits, then a clean frame.
        word = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            SS_n = 1'b0;
            MOSI = (i == 0) ? 1'b0 : word[i];
            step();
        end
        SS_n = 1'b1;
        MOSI = 1'b1;
        step();
        check("abort rx_valid", rx_valid, 0);
        check("abort rx_data kept", rx_data, 10'h300);
        check("abort busy", busy, 0);
        step();
        check("abort rx_valid later", rx_valid, 0);
        send_frame(10'h233);
        check("post-abort rx_valid", rx_valid, 1);
        check("post-abort rx_data", rx_data, 10'h233);
        SS_n = 1'b1;
        step();

        // Final bit lands on a deselected edge, so the frame is incomplete.
        word = 8'h11;
        for (int i = 9; i >= 1; i--) begin
            SS_n = 1'b0;
            MOSI = (i >= 8) ? 1'b0 : word[i];
            step();
        end
        SS_n = 1'b1;
        MOSI = 1'b1;
        step();
        check("9bit rx_valid", rx_valid, 0);
        check("9bit rx_data kept", rx_data, 10'h233);
        step();

        // Two write-data frames back-to-back under one SS_n assertion.
        send_frame(10'h111);
        check("burst1 rx_valid", rx_valid, 1);
        check("burst1 rx_data", rx_data, 10'h111);
        send_frame(10'h122);
`ifdef SPI_SLAVE_STREAM_BURST_EN
        check("burst2 rx_valid", rx_valid, 1);
        check("burst2 rx_data", rx_data, 10'h122);
`else
        check("hold rx_valid", rx_valid, 0);
        check("hold rx_data", rx_data, 10'h111);
        check("hold busy", busy, 1);
`endif
        SS_n = 1'b1;
        step();
        check("burst deselect busy", busy, 0);

        // Reset while the 4th read bit is on MISO; SS_n stays low throughout.
        tx_valid = 1'b1;
        tx_data  = 8'hB7;
        send_frame(10'h300);
        check("rst rd rx_valid", rx_valid, 1);
        step();
        check("rst accept tx_ack", tx_ack, 1);
        check("rst MISO bit7", MISO, 1);
        step();
        check("rst MISO bit6", MISO, 0);
        tx_valid = 1'b0;
        step();
        check("rst MISO bit5", MISO, 1);
        step();
        check("rst MISO bit4", MISO, 1);
        rst_n = 1'b0;
        step();
        check("rst MISO", MISO, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst rx_data", rx_data, 0);
        check("rst tx_ack", tx_ack, 0);
        check("rst busy", busy, 0);
        rst_n = 1'b1;
        SS_n  = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
